// File: rtl/ttt_turn_ctrl_pkg.sv
// Shared definitions for the tic-tac-toe turn controller and its helpers:
// square/marker codes, player ids, winner codes, FSM state encoding and a
// small player-to-marker helper.
package ttt_turn_ctrl_pkg;

  localparam int NUM_SQUARES = 9;

  localparam logic [1:0] BLANK     = 2'b00;
  localparam logic [1:0] MARKER_P1 = 2'b01;
  localparam logic [1:0] MARKER_P2 = 2'b10;

  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_COMMIT = 3'd2,
    ST_EVAL   = 3'd3,
    ST_OVER   = 3'd4
  } state_e;

  function automatic logic [1:0] marker_of(input logic player);
    return (player == PLAYER_2) ? MARKER_P2 : MARKER_P1;
  endfunction

endpackage

// File: rtl/ttt_turn_ctrl_if.sv
// Square-storage write command bus.
//   wr_en     : one-cycle write strobe
//   wr_square : square index 1..9 (held between strobes)
//   wr_marker : 2'd1 player 1, 2'd2 player 2 (held between strobes)
// master = turn controller, slave = square status storage / observer.
interface ttt_turn_ctrl_if;
  logic       wr_en;
  logic [3:0] wr_square;
  logic [1:0] wr_marker;

  modport master (output wr_en, wr_square, wr_marker);
  modport slave  (input  wr_en, wr_square, wr_marker);
endinterface

// File: rtl/ttt_win_check.sv
// Combinational three-in-a-row detector.
//   board    : 18-bit board, bits [2k+1:2k] = square k+1
//   marker   : marker to look for (BLANK never hits)
//   line_hit : 1 when any row, column or diagonal is all `marker`
module ttt_win_check
  import ttt_turn_ctrl_pkg::*;
(
  input  logic [17:0] board,
  input  logic [1:0]  marker,
  output logic        line_hit
);

  logic [NUM_SQUARES-1:0] own;

  for (genvar k = 0; k < NUM_SQUARES; k++) begin : g_sq
    assign own[k] = (marker != BLANK) && (board[2*k +: 2] == marker);
  end

  // own[] index = square-1, laid out row-major 0 1 2 / 3 4 5 / 6 7 8
  assign line_hit = (&own[2:0]) | (&own[5:3]) | (&own[8:6])
                  | (own[0] & own[3] & own[6])
                  | (own[1] & own[4] & own[7])
                  | (own[2] & own[5] & own[8])
                  | (own[0] & own[4] & own[8])
                  | (own[2] & own[4] & own[6]);

endmodule

// File: rtl/ttt_turn_ctrl.sv
// Tic-tac-toe turn controller. Turns a rotary-centre press plus the cursor
// square into a validated one-cycle write to square storage, keeps a shadow
// board, counts moves, alternates turns and detects win/draw.
//   clk, clr_n  : clock, asynchronous active-low clear
//   rot_ctr     : debounced button level; rising edge = press
//   square_num  : cursor square, 1..9 valid
//   new_game    : one-cycle restart pulse (beats everything else)
//   wr          : write command bus (master)
//   player_turn : 0 player 1 to move, 1 player 2
//   board       : shadow board, 2 bits per square
//   move_count  : legal moves this game, 0..9
//   illegal     : one-cycle reject pulse (invalid or occupied square)
//   game_over   : high once the game is decided
//   winner      : 00 none, 01 P1, 10 P2, 11 draw
// Press timeline: CHECK at press+1, wr_en at press+2, board/move_count
// updated from press+3, turn toggle / result visible from press+4.
module ttt_turn_ctrl
  import ttt_turn_ctrl_pkg::*;
#(
  parameter int   SQ_W         = 8,
  parameter logic FIRST_PLAYER = 1'b0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             rot_ctr,
  input  logic [SQ_W-1:0]  square_num,
  input  logic             new_game,
  ttt_turn_ctrl_if.master  wr,
  output logic             player_turn,
  output logic [17:0]      board,
  output logic [3:0]       move_count,
  output logic             illegal,
  output logic             game_over,
  output logic [1:0]       winner
);

  state_e state_q, state_d;

  logic            rot_ctr_q, armed, press;
  logic [SQ_W-1:0] sq_q;
  logic [3:0]      sq_idx;
  logic            sq_valid, legal;
  logic [1:0]      cur_entry;
  logic [17:0]     board_q;
  logic [3:0]      move_count_q;
  logic            player_q, game_over_q;
  logic [1:0]      winner_q, winner_d;
  logic [3:0]      wr_square_q;
  logic [1:0]      wr_marker_q;
  logic            line_hit;
  logic            ld_sq, ld_wr, commit, set_over, toggle;

  // `armed` stays low until the button has been seen released after clear,
  // so a button held through reset release cannot fake a press.
  assign press = rot_ctr & ~rot_ctr_q & armed;

  // Upper sq bits only matter for the validity test; indexing uses [3:0].
  assign sq_valid  = (sq_q != '0) && (sq_q <= SQ_W'(NUM_SQUARES));
  assign sq_idx    = sq_q[3:0] - 4'd1;
  assign cur_entry = 2'(board_q >> {sq_idx, 1'b0});
  assign legal     = sq_valid && (cur_entry == BLANK);

  // In EVAL the board already holds the mover's new marker and player_q has
  // not toggled yet, so the mover is player_q.
  ttt_win_check u_win_check (
    .board    (board_q),
    .marker   (marker_of(player_q)),
    .line_hit (line_hit)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ld_sq    = 1'b0;
    ld_wr    = 1'b0;
    commit   = 1'b0;
    set_over = 1'b0;
    toggle   = 1'b0;
    illegal  = 1'b0;
    winner_d = WIN_NONE;
    case (state_q)
      ST_IDLE: if (press) begin
        ld_sq   = 1'b1;
        state_d = ST_CHECK;
      end
      ST_CHECK: if (!legal) begin
        illegal = 1'b1;
        state_d = ST_IDLE;
      end else begin
        ld_wr   = 1'b1;
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_EVAL;
      end
      ST_EVAL: if (line_hit) begin
        set_over = 1'b1;
        winner_d = (player_q == PLAYER_2) ? WIN_P2 : WIN_P1;
        state_d  = ST_OVER;
      end else if (move_count_q == 4'(NUM_SQUARES)) begin
        set_over = 1'b1;
        winner_d = WIN_DRAW;
        state_d  = ST_OVER;
      end else begin
        toggle  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_OVER: state_d = ST_OVER;
      default: state_d = ST_IDLE;
    endcase
    // Restart wins over everything, including a pending commit.
    if (new_game) begin
      state_d  = ST_IDLE;
      ld_sq    = 1'b0;
      commit   = 1'b0;
      set_over = 1'b0;
      toggle   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rot_ctr_q    <= 1'b0;
      armed        <= 1'b0;
      sq_q         <= '0;
      wr_square_q  <= '0;
      wr_marker_q  <= BLANK;
      board_q      <= '0;
      move_count_q <= '0;
      player_q     <= FIRST_PLAYER;
      winner_q     <= WIN_NONE;
      game_over_q  <= 1'b0;
    end else begin
      rot_ctr_q <= rot_ctr;
      armed     <= armed | ~rot_ctr;
      if (ld_sq) sq_q <= square_num;
      // Command fields are loaded one cycle ahead so they are stable during
      // the strobe and then hold until the next legal move.
      if (ld_wr) begin
        wr_square_q <= sq_q[3:0];
        wr_marker_q <= marker_of(player_q);
      end
      if (new_game) begin
        board_q      <= '0;
        move_count_q <= '0;
        player_q     <= FIRST_PLAYER;
        winner_q     <= WIN_NONE;
        game_over_q  <= 1'b0;
      end else begin
        // Target is known blank, so OR-ing the marker in is a write.
        if (commit) begin
          board_q      <= board_q | (18'(wr_marker_q) << {sq_idx, 1'b0});
          move_count_q <= move_count_q + 4'd1;
        end
        if (set_over) begin
          winner_q    <= winner_d;
          game_over_q <= 1'b1;
        end
        if (toggle) player_q <= ~player_q;
      end
    end
  end

  assign wr.wr_en     = commit;
  assign wr.wr_square = wr_square_q;
  assign wr.wr_marker = wr_marker_q;
  assign player_turn  = player_q;
  assign board        = board_q;
  assign move_count   = move_count_q;
  assign game_over    = game_over_q;
  assign winner       = winner_q;

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
module tb_ttt_turn_ctrl;

  logic        clk = 1'b0;
  logic        clr_n = 1'b1;
  logic        rot_ctr = 1'b0;
  logic [7:0]  square_num = 8'd0;
  logic        new_game = 1'b0;
  logic        player_turn;
  logic [17:0] board;
  logic [3:0]  move_count;
  logic        illegal;
  logic        game_over;
  logic [1:0]  winner;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int ill_cnt  = 0;
  int both_cnt = 0;
  int wr0, ill0;

  localparam int DRAW_SEQ[9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
  localparam int WIN9_SEQ[9] = '{5, 2, 1, 3, 6, 4, 8, 7, 9};

  ttt_turn_ctrl_if wr_if ();

  ttt_turn_ctrl #(.SQ_W(8), .FIRST_PLAYER(1'b0)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .rot_ctr     (rot_ctr),
    .square_num  (square_num),
    .new_game    (new_game),
    .wr          (wr_if.master),
    .player_turn (player_turn),
    .board       (board),
    .move_count  (move_count),
    .illegal     (illegal),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-low-phase after inputs have settled.
  always @(negedge clk) begin
    #3;
    if (wr_if.wr_en) wr_cnt++;
    if (illegal) ill_cnt++;
    if (wr_if.wr_en && illegal) both_cnt++;
  end

  // Returns at the press+1 sample point (CHECK state).
  task automatic do_press(input logic [7:0] sq);
    @(negedge clk);
    square_num = sq;
    rot_ctr    = 1'b1;
    @(negedge clk);
    rot_ctr    = 1'b0;
  endtask

  // Full legal move; returns at press+4.
  task automatic play(input logic [7:0] sq);
    do_press(sq);
    repeat (3) @(negedge clk);
  endtask

  task automatic start_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  task automatic test_reset();
    rot_ctr = 1'b1;
    #1 clr_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (board !== 18'h0) begin n_fail++; $display("FAIL rst_board: got %h want 0", board); end
    n_checks++; if (player_turn !== 1'b0) begin n_fail++; $display("FAIL rst_turn: got %b want 0", player_turn); end
    n_checks++; if (winner !== 2'b00 || game_over !== 1'b0) begin n_fail++; $display("FAIL rst_result: got %b/%b want 00/0", winner, game_over); end
    n_checks++; if (wr_if.wr_en !== 1'b0 || illegal !== 1'b0 || move_count !== 4'd0) begin n_fail++; $display("FAIL rst_pulses: got %b/%b/%0d want 0/0/0", wr_if.wr_en, illegal, move_count); end
    wr0 = wr_cnt; ill0 = ill_cnt;
    clr_n = 1'b1;                         // button still held
    repeat (5) @(negedge clk);
    n_checks++; if (wr_cnt != wr0 || ill_cnt != ill0) begin n_fail++; $display("FAIL rst_held_press: got wr %0d ill %0d want 0 0", wr_cnt - wr0, ill_cnt - ill0); end
    n_checks++; if (board !== 18'h0 || player_turn !== 1'b0) begin n_fail++; $display("FAIL rst_held_state: got %h/%b want 0/0", board, player_turn); end
    rot_ctr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_first_move();
    wr0 = wr_cnt;
    do_press(8'd5);
    n_checks++; if (wr_if.wr_en !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL fm_p1: got wr %b ill %b want 0 0", wr_if.wr_en, illegal); end
    @(negedge clk);
    n_checks++; if (wr_if.wr_en !== 1'b1 || wr_if.wr_square !== 4'd5 || wr_if.wr_marker !== 2'd1) begin n_fail++; $display("FAIL fm_wr: got %b/%0d/%0d want 1/5/1", wr_if.wr_en, wr_if.wr_square, wr_if.wr_marker); end
    @(negedge clk);
    n_checks++; if (wr_if.wr_en !== 1'b0 || board !== 18'h00100 || move_count !== 4'd1 || player_turn !== 1'b0) begin n_fail++; $display("FAIL fm_p3: got wr %b board %h mc %0d turn %b want 0 00100 1 0", wr_if.wr_en, board, move_count, player_turn); end
    @(negedge clk);
    n_checks++; if (player_turn !== 1'b1 || wr_cnt - wr0 != 1) begin n_fail++; $display("FAIL fm_p4: got turn %b wr %0d want 1 1", player_turn, wr_cnt - wr0); end
    n_checks++; if (wr_if.wr_square !== 4'd5 || wr_if.wr_marker !== 2'd1) begin n_fail++; $display("FAIL fm_hold: got %0d/%0d want 5/1", wr_if.wr_square, wr_if.wr_marker); end
  endtask

  task automatic test_illegal();
    wr0 = wr_cnt; ill0 = ill_cnt;
    do_press(8'd5);
    n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL il_occupied: got %b want 1", illegal); end
    @(negedge clk);
    n_checks++; if (wr_if.wr_en !== 1'b0 || illegal !== 1'b0 || player_turn !== 1'b1) begin n_fail++; $display("FAIL il_after: got wr %b ill %b turn %b want 0 0 1", wr_if.wr_en, illegal, player_turn); end
    do_press(8'd0);
    n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL il_zero: got %b want 1", illegal); end
    do_press(8'd12);
    n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL il_twelve: got %b want 1", illegal); end
    do_press(8'd25);                      // low nibble 9, upper bits make it invalid
    n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL il_upper: got %b want 1", illegal); end
    // Held button on an invalid square rejects exactly once.
    @(negedge clk);
    square_num = 8'd0;
    rot_ctr    = 1'b1;
    repeat (6) @(negedge clk);
    rot_ctr    = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (ill_cnt - ill0 != 5 || wr_cnt != wr0) begin n_fail++; $display("FAIL il_counts: got ill %0d wr %0d want 5 0", ill_cnt - ill0, wr_cnt - wr0); end
    n_checks++; if (board !== 18'h00100 || move_count !== 4'd1) begin n_fail++; $display("FAIL il_board: got %h/%0d want 00100/1", board, move_count); end
  endtask

  task automatic test_win();
    start_game();
    n_checks++; if (board !== 18'h0 || move_count !== 4'd0 || player_turn !== 1'b0) begin n_fail++; $display("FAIL win_new: got %h/%0d/%b want 0/0/0", board, move_count, player_turn); end
    play(8'd1); play(8'd4); play(8'd2); play(8'd5);
    n_checks++; if (game_over !== 1'b0 || winner !== 2'b00 || player_turn !== 1'b0) begin n_fail++; $display("FAIL win_pre: got %b/%b/%b want 0/00/0", game_over, winner, player_turn); end
    play(8'd3);
    n_checks++; if (winner !== 2'b01 || game_over !== 1'b1) begin n_fail++; $display("FAIL win_result: got %b/%b want 01/1", winner, game_over); end
    n_checks++; if (board !== 18'h00295 || move_count !== 4'd5 || player_turn !== 1'b0) begin n_fail++; $display("FAIL win_state: got %h/%0d/%b want 00295/5/0", board, move_count, player_turn); end
    wr0 = wr_cnt; ill0 = ill_cnt;
    play(8'd9);
    play(8'd0);
    n_checks++; if (wr_cnt != wr0 || ill_cnt != ill0) begin n_fail++; $display("FAIL win_over_press: got wr %0d ill %0d want 0 0", wr_cnt - wr0, ill_cnt - ill0); end
    n_checks++; if (board !== 18'h00295 || player_turn !== 1'b0 || game_over !== 1'b1) begin n_fail++; $display("FAIL win_frozen: got %h/%b/%b want 00295/0/1", board, player_turn, game_over); end
  endtask

  task automatic test_draw();
    start_game();
    for (int i = 0; i < 9; i++) play(8'(DRAW_SEQ[i]));
    n_checks++; if (winner !== 2'b11 || game_over !== 1'b1 || move_count !== 4'd9) begin n_fail++; $display("FAIL draw_result: got %b/%b/%0d want 11/1/9", winner, game_over, move_count); end
    n_checks++; if (board !== 18'h16A59 || player_turn !== 1'b0) begin n_fail++; $display("FAIL draw_board: got %h/%b want 16a59/0", board, player_turn); end
  endtask

  task automatic test_ninth_win();
    start_game();
    for (int i = 0; i < 9; i++) play(8'(WIN9_SEQ[i]));
    n_checks++; if (winner !== 2'b01 || game_over !== 1'b1 || move_count !== 4'd9) begin n_fail++; $display("FAIL win9_result: got %b/%b/%0d want 01/1/9", winner, game_over, move_count); end
    n_checks++; if (board !== 18'h165A9) begin n_fail++; $display("FAIL win9_board: got %h want 165a9", board); end
  endtask

  task automatic test_back_to_back();
    start_game();
    play(8'd5);
    wr0 = wr_cnt;
    do_press(8'd1);
    @(negedge clk);                       // COMMIT cycle
    new_game = 1'b1;
    #1;
    n_checks++; if (wr_if.wr_en !== 1'b0) begin n_fail++; $display("FAIL ng_commit_wr: got %b want 0", wr_if.wr_en); end
    @(negedge clk);
    new_game = 1'b0;
    n_checks++; if (board !== 18'h0 || move_count !== 4'd0 || player_turn !== 1'b0 || winner !== 2'b00) begin n_fail++; $display("FAIL ng_commit_clear: got %h/%0d/%b/%b want 0/0/0/00", board, move_count, player_turn, winner); end
    n_checks++; if (wr_cnt != wr0) begin n_fail++; $display("FAIL ng_commit_cnt: got %0d want 0", wr_cnt - wr0); end
    do_press(8'd7);
    @(negedge clk);
    n_checks++; if (wr_if.wr_en !== 1'b1 || wr_if.wr_square !== 4'd7 || wr_if.wr_marker !== 2'd1) begin n_fail++; $display("FAIL ng_idle_next: got %b/%0d/%0d want 1/7/1", wr_if.wr_en, wr_if.wr_square, wr_if.wr_marker); end
    repeat (2) @(negedge clk);
    // Clear asserted during EVAL of player 2's move.
    do_press(8'd3);
    repeat (2) @(negedge clk);
    clr_n = 1'b0;
    #1;
    n_checks++; if (board !== 18'h0 || move_count !== 4'd0 || player_turn !== 1'b0 || winner !== 2'b00 || game_over !== 1'b0) begin n_fail++; $display("FAIL clr_eval: got %h/%0d/%b/%b/%b want 0/0/0/00/0", board, move_count, player_turn, winner, game_over); end
    @(negedge clk);
    clr_n = 1'b1;
    play(8'd9);
    n_checks++; if (board !== 18'h10000 || player_turn !== 1'b1 || move_count !== 4'd1) begin n_fail++; $display("FAIL clr_resume: got %h/%b/%0d want 10000/1/1", board, player_turn, move_count); end
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_illegal();
    test_win();
    test_draw();
    test_ninth_win();
    test_back_to_back();
    @(negedge clk);
    n_checks++; if (both_cnt != 0) begin n_fail++; $display("FAIL wr_and_illegal: got %0d cycles want 0", both_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
